// File: rtl/nn_train_sequencer_pkg.sv
// Shared types and defaults for the nn_train_sequencer fp/bp host initiator.
package nn_train_sequencer_pkg;

  localparam int unsigned NUM_WIDTH_DEF   = 16;
  localparam int unsigned INPUT_SIZE_DEF  = 4;
  localparam int unsigned OUTPUT_SIZE_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 1023;
  localparam int unsigned CNT_WIDTH_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FP_ISSUE = 3'd1,
    ST_FP_WAIT  = 3'd2,
    ST_BP_ISSUE = 3'd3,
    ST_BP_WAIT  = 3'd4,
    ST_RESULT   = 3'd5
  } state_t;

endpackage

// File: rtl/nn_train_sequencer_argmax_comb.sv
// Combinational signed argmax over a packed vector; lowest index wins ties.
module nn_train_sequencer_argmax_comb #(
  parameter int unsigned NUM_WIDTH = 16,
  parameter int unsigned NUM_ELEMS = 4
) (
  input  logic [NUM_ELEMS*NUM_WIDTH-1:0]  vec_pk,
  output logic [$clog2(NUM_ELEMS)-1:0]    idx
);

  localparam int unsigned IDX_W = $clog2(NUM_ELEMS);

  logic signed [NUM_WIDTH-1:0] best_c;

  // Strict greater-than keeps the earliest maximum on ties.
  always_comb begin
    best_c = $signed(vec_pk[NUM_WIDTH-1:0]);
    idx    = '0;
    for (int unsigned i = 1; i < NUM_ELEMS; i++) begin
      if ($signed(vec_pk[i*NUM_WIDTH +: NUM_WIDTH]) > best_c) begin
        best_c = $signed(vec_pk[i*NUM_WIDTH +: NUM_WIDTH]);
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nn_train_sequencer.sv
// Host-side fp/bp pulse initiator for neural_network: sample in, a3 result out.
// Optional argmax/correctness reporting under NN_TRAIN_SEQ_ARGMAX_EN.
module nn_train_sequencer
  import nn_train_sequencer_pkg::*;
#(
  parameter int unsigned NUM_WIDTH   = NUM_WIDTH_DEF,
  parameter int unsigned INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int unsigned OUTPUT_SIZE = OUTPUT_SIZE_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_train,
  input  logic [INPUT_SIZE*NUM_WIDTH-1:0]   s_x_pk,
  input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  s_y_pk,
  output logic                              nn_fp,
  input  logic                              nn_fp_out,
  output logic [INPUT_SIZE*NUM_WIDTH-1:0]   nn_a0_pk,
  input  logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  nn_a3_pk,
  output logic                              nn_bp,
  input  logic                              nn_bp_out,
  output logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  nn_g3_pk,
  output logic                              r_valid,
  input  logic                              r_ready,
  output logic [OUTPUT_SIZE*NUM_WIDTH-1:0]  r_y_pk,
  output logic                              r_timeout,
  output logic                              busy,
  output logic [CNT_WIDTH-1:0]              sample_cnt
`ifdef NN_TRAIN_SEQ_ARGMAX_EN
  ,
  output logic [$clog2(OUTPUT_SIZE)-1:0]    r_pred,
  output logic                              r_correct,
  output logic [CNT_WIDTH-1:0]              correct_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t            state;
  logic              train_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired_c;

  // Expiry on the TIMEOUT-th waiting cycle; a done pulse in that cycle still wins.
  assign wait_expired_c = (wait_cnt == WAIT_LAST);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      train_q    <= 1'b0;
      wait_cnt   <= '0;
      s_ready    <= 1'b0;
      nn_fp      <= 1'b0;
      nn_bp      <= 1'b0;
      nn_a0_pk   <= '0;
      nn_g3_pk   <= '0;
      r_valid    <= 1'b0;
      r_y_pk     <= '0;
      r_timeout  <= 1'b0;
      busy       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      nn_fp <= 1'b0;
      nn_bp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            nn_a0_pk <= s_x_pk;
            nn_g3_pk <= s_y_pk;
            train_q  <= s_train;
            s_ready  <= 1'b0;
            nn_fp    <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_FP_ISSUE;
          end
        end
        ST_FP_ISSUE, ST_FP_WAIT: begin
          if (nn_fp_out) begin
            r_y_pk    <= nn_a3_pk;
            r_timeout <= 1'b0;
            if (train_q) begin
              nn_bp <= 1'b1;
              state <= ST_BP_ISSUE;
            end else begin
              r_valid <= 1'b1;
              state   <= ST_RESULT;
            end
          end else if (state == ST_FP_ISSUE) begin
            wait_cnt <= '0;
            state    <= ST_FP_WAIT;
          end else if (wait_expired_c) begin
            r_y_pk    <= '0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_BP_ISSUE, ST_BP_WAIT: begin
          if (nn_bp_out) begin
            r_valid <= 1'b1;
            state   <= ST_RESULT;
          end else if (state == ST_BP_ISSUE) begin
            wait_cnt <= '0;
            state    <= ST_BP_WAIT;
          end else if (wait_expired_c) begin
            r_y_pk    <= '0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            state     <= ST_RESULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_RESULT: begin
          // s_ready rises with the handshake so the next accept lands one IDLE cycle later.
          if (r_ready) begin
            r_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
            if (!r_timeout && (sample_cnt != CNT_MAX)) begin
              sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NN_TRAIN_SEQ_ARGMAX_EN
  localparam int unsigned IDX_W = $clog2(OUTPUT_SIZE);

  logic [IDX_W-1:0] a3_idx_c;
  logic [IDX_W-1:0] g3_idx_c;
  logic             fp_capture_c;
  logic             timeout_c;
  logic             result_hs_c;

  nn_train_sequencer_argmax_comb #(
    .NUM_WIDTH (NUM_WIDTH),
    .NUM_ELEMS (OUTPUT_SIZE)
  ) u_argmax_a3 (
    .vec_pk (nn_a3_pk),
    .idx    (a3_idx_c)
  );

  nn_train_sequencer_argmax_comb #(
    .NUM_WIDTH (NUM_WIDTH),
    .NUM_ELEMS (OUTPUT_SIZE)
  ) u_argmax_g3 (
    .vec_pk (nn_g3_pk),
    .idx    (g3_idx_c)
  );

  assign fp_capture_c = ((state == ST_FP_ISSUE) || (state == ST_FP_WAIT)) && nn_fp_out;
  assign timeout_c    = wait_expired_c &&
                        (((state == ST_FP_WAIT) && !nn_fp_out) ||
                         ((state == ST_BP_WAIT) && !nn_bp_out));
  assign result_hs_c  = (state == ST_RESULT) && r_ready;

  // Prediction is taken alongside a3 capture; ground truth is stable since accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred      <= '0;
      r_correct   <= 1'b0;
      correct_cnt <= '0;
    end else begin
      if (fp_capture_c) begin
        r_pred    <= a3_idx_c;
        r_correct <= (a3_idx_c == g3_idx_c);
      end else if (timeout_c) begin
        r_pred    <= '0;
        r_correct <= 1'b0;
      end
      if (result_hs_c && !r_timeout && r_correct && (correct_cnt != CNT_MAX)) begin
        correct_cnt <= correct_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Directed bench for nn_train_sequencer; network responses are driven by hand at fixed cycles.
module tb_nn_train_sequencer;

  localparam int unsigned NW = 16;
  localparam int unsigned IS = 4;
  localparam int unsigned OS = 4;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 16;

  localparam logic [63:0] X1 = 64'h0000_0000_0000_0100;
  localparam logic [63:0] Y1 = 64'h0000_0000_0000_0100;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_0100;
  localparam logic [63:0] X2 = 64'h0001_0002_0003_0004;
  localparam logic [63:0] Y2 = 64'h0100_0000_0000_0000;
  localparam logic [63:0] A2 = 64'h0010_FFF0_0020_0030;
  localparam logic [63:0] X3 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] Y3 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] X4 = 64'h0404_0404_0404_0404;
  localparam logic [63:0] Y4 = 64'h0000_0100_0000_0000;
  localparam logic [63:0] A4 = 64'h7FFF_8000_0001_0002;
  localparam logic [63:0] X5 = 64'h0505_0505_0505_0505;
  localparam logic [63:0] Y5 = 64'h5555_0000_0000_0000;
  localparam logic [63:0] A5 = 64'h0050_0050_0050_0050;
  localparam logic [63:0] X6 = 64'h0600_0000_0000_0006;
  localparam logic [63:0] Y6 = 64'h0000_0000_0100_0000;
  localparam logic [63:0] A6 = 64'h0000_0000_0000_0200;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, s_train;
  logic [IS*NW-1:0] s_x_pk, nn_a0_pk;
  logic [OS*NW-1:0] s_y_pk, nn_a3_pk, nn_g3_pk, r_y_pk;
  logic nn_fp, nn_fp_out, nn_bp, nn_bp_out;
  logic r_valid, r_ready, r_timeout, busy;
  logic [CW-1:0] sample_cnt;
`ifdef NN_TRAIN_SEQ_ARGMAX_EN
  logic [$clog2(OS)-1:0] r_pred;
  logic r_correct;
  logic [CW-1:0] correct_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int fp_cnt = 0;
  int bp_cnt = 0;

  nn_train_sequencer #(
    .NUM_WIDTH   (NW),
    .INPUT_SIZE  (IS),
    .OUTPUT_SIZE (OS),
    .TIMEOUT     (TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_train    (s_train),
    .s_x_pk     (s_x_pk),
    .s_y_pk     (s_y_pk),
    .nn_fp      (nn_fp),
    .nn_fp_out  (nn_fp_out),
    .nn_a0_pk   (nn_a0_pk),
    .nn_a3_pk   (nn_a3_pk),
    .nn_bp      (nn_bp),
    .nn_bp_out  (nn_bp_out),
    .nn_g3_pk   (nn_g3_pk),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_y_pk     (r_y_pk),
    .r_timeout  (r_timeout),
    .busy       (busy),
    .sample_cnt (sample_cnt)
`ifdef NN_TRAIN_SEQ_ARGMAX_EN
    ,
    .r_pred      (r_pred),
    .r_correct   (r_correct),
    .correct_cnt (correct_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pulse counters for nn_fp / nn_bp, sampled mid-cycle.
  always @(negedge clk) begin
    if (nn_fp === 1'b1) fp_cnt++;
    if (nn_bp === 1'b1) bp_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_train = 1'b0; s_x_pk = '0; s_y_pk = '0;
    nn_fp_out = 1'b0; nn_a3_pk = '0; nn_bp_out = 1'b0; r_ready = 1'b0;
    cyc(2);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_nn_fp", 64'(nn_fp), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Inference: fp_out 5 cycles after nn_fp.
    s_valid = 1'b1; s_train = 1'b0; s_x_pk = X1; s_y_pk = Y1;
    cyc(1);
    s_valid = 1'b0; s_x_pk = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("inf_fp_c1", 64'(nn_fp), 64'd1);
    chk("inf_s_ready_c1", 64'(s_ready), 64'd0);
    chk("inf_busy_c1", 64'(busy), 64'd1);
    chk("inf_a0_c1", nn_a0_pk, X1);
    cyc(1);
    chk("inf_fp_c2", 64'(nn_fp), 64'd0);
    cyc(4);
    chk("inf_rvalid_c6", 64'(r_valid), 64'd0);
    nn_fp_out = 1'b1; nn_a3_pk = A1;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("inf_rvalid_c7", 64'(r_valid), 64'd1);
    chk("inf_ry_c7", r_y_pk, A1);
    chk("inf_timeout_c7", 64'(r_timeout), 64'd0);
    chk("inf_a0_held", nn_a0_pk, X1);
    chk("inf_no_bp", 64'(bp_cnt), 64'd0);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("inf_rvalid_done", 64'(r_valid), 64'd0);
    chk("inf_sample_cnt", 64'(sample_cnt), 64'd1);
    chk("inf_s_ready_idle", 64'(s_ready), 64'd1);
    chk("inf_busy_idle", 64'(busy), 64'd0);

    // Training: fp_out at F=6, bp_out 8 cycles after nn_bp.
    s_valid = 1'b1; s_train = 1'b1; s_x_pk = X2; s_y_pk = Y2;
    cyc(1);
    s_valid = 1'b0; s_y_pk = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("trn_fp_c1", 64'(nn_fp), 64'd1);
    chk("trn_g3_c1", nn_g3_pk, Y2);
    cyc(5);
    nn_fp_out = 1'b1; nn_a3_pk = A2;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("trn_bp_c7", 64'(nn_bp), 64'd1);
    chk("trn_rvalid_c7", 64'(r_valid), 64'd0);
    chk("trn_g3_c7", nn_g3_pk, Y2);
    cyc(1);
    chk("trn_bp_c8", 64'(nn_bp), 64'd0);
    cyc(7);
    chk("trn_rvalid_c15", 64'(r_valid), 64'd0);
    nn_bp_out = 1'b1;
    cyc(1);
    nn_bp_out = 1'b0;
    chk("trn_rvalid_c16", 64'(r_valid), 64'd1);
    chk("trn_ry_c16", r_y_pk, A2);
    chk("trn_bp_once", 64'(bp_cnt), 64'd1);
    chk("trn_g3_c16", nn_g3_pk, Y2);

    // Back-pressure: r_ready low 10 cycles while the next sample is offered.
    s_valid = 1'b1; s_train = 1'b0; s_x_pk = X3; s_y_pk = Y3;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rvalid_hold", 64'(r_valid), 64'd1);
      chk("bp_ry_hold", r_y_pk, A2);
      chk("bp_s_ready_low", 64'(s_ready), 64'd0);
      cyc(1);
    end
    chk("bp_rvalid_pre_hs", 64'(r_valid), 64'd1);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("bp_idle_s_ready", 64'(s_ready), 64'd1);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_rvalid", 64'(r_valid), 64'd0);
    chk("bp_sample_cnt", 64'(sample_cnt), 64'd2);
    chk("bp_fp_count", 64'(fp_cnt), 64'd2);

    // Timeout: sample accepted in that IDLE cycle, fp_out never arrives.
    cyc(1);
    s_valid = 1'b0;
    chk("to_fp_c1", 64'(nn_fp), 64'd1);
    chk("to_a0_c1", nn_a0_pk, X3);
    cyc(20);
    chk("to_rvalid_c21", 64'(r_valid), 64'd0);
    chk("to_busy_c21", 64'(busy), 64'd1);
    cyc(1);
    chk("to_rvalid_c22", 64'(r_valid), 64'd1);
    chk("to_flag_c22", 64'(r_timeout), 64'd1);
    chk("to_ry_zero", r_y_pk, 64'd0);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("to_sample_cnt", 64'(sample_cnt), 64'd2);
    chk("to_rvalid_done", 64'(r_valid), 64'd0);
    nn_fp_out = 1'b1; nn_a3_pk = A1;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0; nn_bp_out = 1'b1;
    cyc(1);
    nn_bp_out = 1'b0;
    cyc(1);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_rvalid", 64'(r_valid), 64'd0);
    chk("stray_ry", r_y_pk, 64'd0);
    chk("stray_s_ready", 64'(s_ready), 64'd1);

    // fp_out on the expiry cycle wins; bp_out while in FP_WAIT is ignored.
    s_valid = 1'b1; s_train = 1'b0; s_x_pk = X4; s_y_pk = Y4;
    cyc(1);
    s_valid = 1'b0;
    cyc(4);
    nn_bp_out = 1'b1;
    cyc(1);
    nn_bp_out = 1'b0;
    cyc(15);
    chk("exp_rvalid_c21", 64'(r_valid), 64'd0);
    nn_fp_out = 1'b1; nn_a3_pk = A4;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("exp_rvalid_c22", 64'(r_valid), 64'd1);
    chk("exp_timeout_c22", 64'(r_timeout), 64'd0);
    chk("exp_ry_c22", r_y_pk, A4);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("exp_sample_cnt", 64'(sample_cnt), 64'd3);
    chk("exp_no_bp", 64'(bp_cnt), 64'd1);

    // Async reset while in BP_WAIT.
    s_valid = 1'b1; s_train = 1'b1; s_x_pk = X5; s_y_pk = Y5;
    cyc(1);
    s_valid = 1'b0;
    cyc(2);
    nn_fp_out = 1'b1; nn_a3_pk = A5;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("rst5_bp_c4", 64'(nn_bp), 64'd1);
    cyc(2);
    chk("rst5_busy_c6", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_nn_bp", 64'(nn_bp), 64'd0);
    chk("rstmid_rvalid", 64'(r_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd0);
    chk("rstmid_g3", nn_g3_pk, 64'd0);
    cyc(1);
    rst = 1'b0; nn_bp_out = 1'b1;
    cyc(1);
    nn_bp_out = 1'b0;
    chk("late_bp_busy", 64'(busy), 64'd0);
    chk("late_bp_rvalid", 64'(r_valid), 64'd0);
    chk("late_bp_s_ready", 64'(s_ready), 64'd1);

    // Normal sample after reset; fp_out arrives during FP_ISSUE.
    s_valid = 1'b1; s_train = 1'b0; s_x_pk = X6; s_y_pk = Y6;
    cyc(1);
    s_valid = 1'b0; nn_fp_out = 1'b1; nn_a3_pk = A6;
    chk("s6_fp_c1", 64'(nn_fp), 64'd1);
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("s6_fp_c2", 64'(nn_fp), 64'd0);
    chk("s6_rvalid_c2", 64'(r_valid), 64'd1);
    chk("s6_ry_c2", r_y_pk, A6);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("s6_sample_cnt", 64'(sample_cnt), 64'd1);
    chk("fp_total", 64'(fp_cnt), 64'd6);

`ifdef NN_TRAIN_SEQ_ARGMAX_EN
    chk("am_correct_cnt_s6", 64'(correct_cnt), 64'd0);
    s_valid = 1'b1; s_train = 1'b0; s_x_pk = X1; s_y_pk = 64'h0000_0000_0001_0000;
    cyc(1);
    s_valid = 1'b0; nn_fp_out = 1'b1; nn_a3_pk = 64'hFFFD_0009_0009_0005;
    cyc(1);
    nn_fp_out = 1'b0; nn_a3_pk = '0;
    chk("am_rvalid", 64'(r_valid), 64'd1);
    chk("am_r_pred", 64'(r_pred), 64'd1);
    chk("am_r_correct", 64'(r_correct), 64'd1);
    r_ready = 1'b1;
    cyc(1);
    r_ready = 1'b0;
    chk("am_correct_cnt", 64'(correct_cnt), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_train_sequencer.md
Name: nn_train_sequencer

Overview:
- Host-side initiator for the neural network's fp/bp pulse protocol; `neural_network` is the responder.
- Accepts one sample (inputs, ground truth, train flag) over a valid/ready stream and drives a0/g3.
- Issues a one-cycle fp pulse and waits for fp_out, then captures a3. In train mode it then issues a one-cycle bp pulse and waits for bp_out.
- Returns a3 over a valid/ready result stream. Sits between the sample source (DMA/host regs) and neural_network.

Parameters:
NUM_WIDTH, 16, fixed-point word width; must match network NUM_WIDTH
INPUT_SIZE, 4, number of input-layer neurons
OUTPUT_SIZE, 4, number of output-layer neurons
TIMEOUT, 1023, maximum cycles spent waiting in FP_WAIT or BP_WAIT before abort
CNT_WIDTH, 16, width of the completed-sample counter

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  sample valid
s_ready  out  1  sample ready; high only in IDLE
s_train  in  1  1 = forward+backward pass, 0 = inference only
s_x_pk  in  INPUT_SIZE*NUM_WIDTH  packed input vector
s_y_pk  in  OUTPUT_SIZE*NUM_WIDTH  packed ground truth
nn_fp  out  1  forward-pass start pulse to network
nn_fp_out  in  1  forward-pass done pulse from network
nn_a0_pk  out  INPUT_SIZE*NUM_WIDTH  held input vector
nn_a3_pk  in  OUTPUT_SIZE*NUM_WIDTH  network output
nn_bp  out  1  backward-pass start pulse
nn_bp_out  in  1  backward-pass done pulse
nn_g3_pk  out  OUTPUT_SIZE*NUM_WIDTH  held ground truth
r_valid  out  1  result valid
r_ready  in  1  result ready
r_y_pk  out  OUTPUT_SIZE*NUM_WIDTH  captured a3
r_timeout  out  1  result aborted by timeout; qualified by r_valid
busy  out  1  high in any state other than IDLE; external weight-update logic must not assert wu while busy
sample_cnt  out  CNT_WIDTH  completed non-timeout samples, saturating

Behaviour:
- Reset values: all outputs 0 (s_ready = 0 during reset); state = IDLE; first cycle after reset deasserts, s_ready = 1.
- States and transitions:
  - IDLE: s_ready = 1. On s_valid && s_ready, latch s_x_pk→nn_a0_pk, s_y_pk→nn_g3_pk and s_train; go to FP_ISSUE.
  - FP_ISSUE: nn_fp = 1 for exactly this cycle; go to FP_WAIT.
  - FP_WAIT: wait for nn_fp_out.
  - BP_ISSUE: nn_bp = 1 for exactly this cycle; go to BP_WAIT.
  - BP_WAIT: wait for nn_bp_out.
  - RESULT: r_valid = 1, held with r_y_pk/r_timeout stable until r_ready; on r_valid && r_ready go to IDLE.
- Forward completion: nn_fp_out sampled in FP_ISSUE or FP_WAIT captures nn_a3_pk into r_y_pk that cycle. Next state is BP_ISSUE if the latched train flag is set, else RESULT.
- Backward completion: nn_bp_out sampled in BP_ISSUE or BP_WAIT → RESULT.
- nn_a0_pk and nn_g3_pk are held from accept until the return to IDLE; they change only on accept.
- Latency (accept at cycle 0, fp_out at cycle F, bp_out at cycle B):
  - nn_fp at cycle 1.
  - Inference: r_valid at F+1.
  - Train: nn_bp at F+1, r_valid at B+1.
- Timeout: a wait counter clears on entry to FP_WAIT/BP_WAIT and increments each waiting cycle. When it reaches TIMEOUT without the done pulse, go to RESULT with r_timeout = 1 and r_y_pk = 0. A done pulse in the same cycle as expiry wins (normal completion).
- sample_cnt increments by 1 on each result handshake with r_timeout = 0; it saturates at all-ones.
- Stray nn_fp_out/nn_bp_out in IDLE, RESULT, or the wrong wait state are ignored.
- Reset mid-operation returns immediately to IDLE. Pulses drop, latched data clears, sample_cnt clears. Late done pulses from the network are then ignored per the stray-pulse rule.
- A new sample is never accepted in the same cycle as a result handshake; minimum one IDLE cycle between samples.

Optional Feature:
- Macro: NN_TRAIN_SEQ_ARGMAX_EN.
- When defined:
  - Adds outputs r_pred (clog2(OUTPUT_SIZE) bits) and r_correct (1 bit), both valid with r_valid.
  - r_pred is the index of the largest a3 element, compared as signed, lowest index on ties; registered at a3 capture.
  - r_correct = 1 when r_pred equals the argmax of the latched ground truth.
  - Adds correct_cnt (CNT_WIDTH, saturating), incremented on non-timeout result handshakes with r_correct = 1.
- When undefined: these ports and their logic are absent.

Decomposition:
- Shared package: state encoding localparams (IDLE, FP_ISSUE, FP_WAIT, BP_ISSUE, BP_WAIT, RESULT).
- Width macros NUM_WIDTH/INPUT_SIZE/OUTPUT_SIZE come from the existing global defines header; the pack/unpack macros are reused.
- One natural sub-module: argmax_comb (combinational signed argmax over a packed vector), instantiated twice under NN_TRAIN_SEQ_ARGMAX_EN.

Test Plan:
- Inference: s_train = 0, x = {1.0, 0, 0, 0}; network model returns fp_out 5 cycles after nn_fp with a3 = {0x0100, 0, 0, 0}. Required: nn_fp at cycle 1, r_valid at cycle 7, r_y_pk equals a3, nn_bp never asserted, sample_cnt = 1.
- Training: s_train = 1; fp_out at F = 6, bp_out 8 cycles after nn_bp. Required: nn_bp single pulse at cycle 7, r_valid at cycle 16, nn_g3_pk stable throughout.
- Back-pressure: r_ready held low for 10 cycles. Required: r_valid and r_y_pk stable, s_ready = 0 throughout, accept only after the handshake plus one IDLE cycle.
- Timeout: TIMEOUT = 20, model never pulses fp_out. Required: r_valid with r_timeout = 1 and r_y_pk = 0 after 20 wait cycles; sample_cnt unchanged. A late fp_out after return to IDLE is ignored.
- Reset mid-BP_WAIT: assert rst asynchronously. Required: nn_bp, r_valid, busy and sample_cnt all 0 immediately. A subsequent bp_out is ignored and the next sample runs normally.
- ARGMAX_EN: a3 = {5, 9, 9, -3}, g3 = {0, 1, 0, 0}. Required: r_pred = 1, r_correct = 1, correct_cnt = 1.
